// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN accelerator datapath.
//  - cnn_mode_t    : layer mode encoding used by the controller
//  - fetch_state_t : operand_fetch window sequencer state
//  - fetch_entry_t : one operand entry streamed to the PE array
// The entry layout is fixed by FETCH_DATA_W / FETCH_KSIZE. Modules that
// carry entries must be built with matching DATA_W / KSIZE.
package cnn_pkg;

  localparam int FETCH_DATA_W = 16;
  localparam int FETCH_KSIZE  = 9;
  localparam int TAP_W        = 4;

  typedef enum logic [1:0] {
    MODE_CONVOLUTION = 2'd0,
    MODE_POOLING     = 2'd1,
    MODE_FULLY       = 2'd2,
    MODE_RESERVED    = 2'd3
  } cnn_mode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_WIN = 2'd1,
    STREAM   = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0]             ifm;
    logic [FETCH_KSIZE*FETCH_DATA_W-1:0] wgt;
    logic                                wgt_load;
    logic [FETCH_DATA_W-1:0]             bias;
    logic                                bias_load;
    logic [TAP_W-1:0]                    tap;
    logic                                last;
  } fetch_entry_t;

endpackage

// File: rtl/operand_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t.
// Ports: clk, rst (async, active-high), flush (drops all entries),
//        push/wdata, pop/rdata (show-ahead), full, empty, count.
// A push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
  import cnn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  output fetch_entry_t               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            wr_en;
  logic            rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity,
  // which keeps the array as plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: converts controller read strobes into IFM/weight/bias SRAM
// reads and streams packed per-tap operand entries to the PE array.
// Ports:
//  cfg_start, cfg_*_base, cfg_ifm_stride : window configuration / restart
//  ifm_read, wgt_read, bias_read        : controller strobes (never stalled)
//  ifm_/wgt_/bias_ en, addr, rdata      : SRAM ports, 1-cycle read latency
//  pe_valid/pe_ready, pe_*              : operand stream to the PE array
//  err_drop                             : sticky, a strobe found no credit
// Optional build macro FETCH_PERF_EN adds perf_drop_cnt / perf_stall_cnt.
// DATA_W and KSIZE must match the cnn_pkg entry layout.
module operand_fetch
  import cnn_pkg::*;
#(
  parameter int DATA_W     = FETCH_DATA_W,
  parameter int KSIZE      = FETCH_KSIZE,
  parameter int IFM_AW     = 10,
  parameter int WGT_AW     = 8,
  parameter int BIAS_AW    = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [IFM_AW-1:0]       cfg_ifm_base,
  input  logic [IFM_AW-1:0]       cfg_ifm_stride,
  input  logic [WGT_AW-1:0]       cfg_wgt_base,
  input  logic [BIAS_AW-1:0]      cfg_bias_base,
  input  logic                    ifm_read,
  input  logic                    wgt_read,
  input  logic                    bias_read,
  output logic                    ifm_en,
  output logic [IFM_AW-1:0]       ifm_addr,
  input  logic [DATA_W-1:0]       ifm_rdata,
  output logic                    wgt_en,
  output logic [WGT_AW-1:0]       wgt_addr,
  input  logic [KSIZE*DATA_W-1:0] wgt_rdata,
  output logic                    bias_en,
  output logic [BIAS_AW-1:0]      bias_addr,
  input  logic [DATA_W-1:0]       bias_rdata,
  output logic                    pe_valid,
  input  logic                    pe_ready,
  output logic [DATA_W-1:0]       pe_ifm,
  output logic [KSIZE*DATA_W-1:0] pe_wgt,
  output logic                    pe_wgt_load,
  output logic [DATA_W-1:0]       pe_bias,
  output logic                    pe_bias_load,
  output logic [3:0]              pe_tap,
  output logic                    pe_last,
  output logic                    err_drop
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]             perf_drop_cnt,
  output logic [15:0]             perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t        state, state_nxt;
  logic [TAP_W-1:0]    tap;
  logic [IFM_AW-1:0]   ifm_ptr, win_base, stride;
  logic [WGT_AW-1:0]   wgt_ptr;
  logic [BIAS_AW-1:0]  bias_ptr;

  // Read issued last cycle; its SRAM data is on the rdata buses now.
  logic                inflight, inf_wgt, inf_bias, inf_last;
  logic [TAP_W-1:0]    inf_tap;

  logic                want, start_win, credit, issue, drop, pop;
  logic [TAP_W-1:0]    issue_tap;
  logic                issue_last;
  logic [CNT_W:0]      occupancy;

  fetch_entry_t        push_entry, head;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  assign pe_valid  = !fifo_empty;
  assign pop       = pe_valid && pe_ready;
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    want       = 1'b0;
    start_win  = 1'b0;
    state_nxt  = state;
    case (state)
      WAIT_WIN: begin
        // ifm_read alone here is the controller's trailing hold cycle.
        want      = ifm_read && wgt_read;
        start_win = 1'b1;
      end
      STREAM: begin
        want      = ifm_read;
        start_win = wgt_read;
      end
      default: ;
    endcase
    if (cfg_start) want = 1'b0;

    // A pop this cycle frees a slot for the read issued now, so a full
    // FIFO being drained every cycle keeps accepting strobes.
    credit     = (occupancy < (CNT_W+1)'(FIFO_DEPTH)) ||
                 (pop && !(fifo_full && inflight));
    issue      = want && credit;
    drop       = want && !credit;
    issue_tap  = start_win ? '0 : tap;
    issue_last = (issue_tap == TAP_W'(KSIZE - 1));

    ifm_en    = issue;
    ifm_addr  = '0;
    wgt_en    = issue && start_win;
    wgt_addr  = '0;
    bias_en   = issue && start_win && bias_read;
    bias_addr = '0;
    if (issue)   ifm_addr  = start_win ? win_base : ifm_ptr;
    if (wgt_en)  wgt_addr  = wgt_ptr;
    if (bias_en) bias_addr = bias_ptr;

    if (issue) state_nxt = issue_last ? WAIT_WIN : STREAM;
    if (cfg_start) state_nxt = WAIT_WIN;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap      <= '0;
      ifm_ptr  <= '0;
      win_base <= '0;
      stride   <= '0;
      wgt_ptr  <= '0;
      bias_ptr <= '0;
    end else if (cfg_start) begin
      tap      <= '0;
      ifm_ptr  <= cfg_ifm_base;
      win_base <= cfg_ifm_base;
      stride   <= cfg_ifm_stride;
      wgt_ptr  <= cfg_wgt_base;
      bias_ptr <= cfg_bias_base;
    end else if (issue) begin
      if (wgt_en)  wgt_ptr  <= wgt_ptr + 1'b1;
      if (bias_en) bias_ptr <= bias_ptr + 1'b1;
      if (issue_last) begin
        tap      <= '0;
        win_base <= win_base + stride;
        ifm_ptr  <= win_base + stride;
      end else begin
        tap      <= issue_tap + 1'b1;
        ifm_ptr  <= ifm_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      inf_wgt  <= 1'b0;
      inf_bias <= 1'b0;
      inf_last <= 1'b0;
      inf_tap  <= '0;
      err_drop <= 1'b0;
    end else begin
      inflight <= issue;
      inf_wgt  <= wgt_en;
      inf_bias <= bias_en;
      inf_last <= issue_last;
      inf_tap  <= issue_tap;
      if (cfg_start) err_drop <= 1'b0;
      else if (drop) err_drop <= 1'b1;
    end
  end

  always_comb begin
    push_entry           = '0;
    push_entry.ifm       = ifm_rdata;
    push_entry.wgt_load  = inf_wgt;
    push_entry.bias_load = inf_bias;
    push_entry.tap       = inf_tap;
    push_entry.last      = inf_last;
    if (inf_wgt)  push_entry.wgt  = wgt_rdata;
    if (inf_bias) push_entry.bias = bias_rdata;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (cfg_start),
    .push  (inflight),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    pe_ifm       = '0;
    pe_wgt       = '0;
    pe_wgt_load  = 1'b0;
    pe_bias      = '0;
    pe_bias_load = 1'b0;
    pe_tap       = '0;
    pe_last      = 1'b0;
    if (pe_valid) begin
      pe_ifm       = head.ifm;
      pe_wgt       = head.wgt;
      pe_wgt_load  = head.wgt_load;
      pe_bias      = head.bias;
      pe_bias_load = head.bias_load;
      pe_tap       = head.tap;
      pe_last      = head.last;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_drop_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else if (cfg_start) begin
      perf_drop_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (drop && perf_drop_cnt != 16'hFFFF)
        perf_drop_cnt <= perf_drop_cnt + 1'b1;
      if (pe_valid && !pe_ready && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  import cnn_pkg::*;

  localparam int DATA_W = 16, KSIZE = 9, IFM_AW = 10, WGT_AW = 8, BIAS_AW = 6;

  logic clk = 1'b0, rst = 1'b1, cfg_start = 1'b0;
  logic [IFM_AW-1:0] cfg_ifm_base = '0, cfg_ifm_stride = '0;
  logic [WGT_AW-1:0] cfg_wgt_base = '0;
  logic [BIAS_AW-1:0] cfg_bias_base = '0;
  logic ifm_read = 1'b0, wgt_read = 1'b0, bias_read = 1'b0, pe_ready = 1'b0;
  logic ifm_en, wgt_en, bias_en;
  logic [IFM_AW-1:0] ifm_addr;
  logic [WGT_AW-1:0] wgt_addr;
  logic [BIAS_AW-1:0] bias_addr;
  logic [DATA_W-1:0] ifm_rdata = '0, bias_rdata = '0;
  logic [KSIZE*DATA_W-1:0] wgt_rdata = '0;
  logic pe_valid, pe_wgt_load, pe_bias_load, pe_last, err_drop;
  logic [DATA_W-1:0] pe_ifm, pe_bias;
  logic [KSIZE*DATA_W-1:0] pe_wgt;
  logic [3:0] pe_tap;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_drop_cnt, perf_stall_cnt;
`endif

  int n_checks = 0, n_pass = 0, n_fail = 0;
  fetch_entry_t sb[$];

  // Bench-side window model
  logic [IFM_AW-1:0] m_win, m_stride;
  logic [WGT_AW-1:0] m_wgt;
  logic [BIAS_AW-1:0] m_bias;
  int m_tap = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_ifm_base(cfg_ifm_base), .cfg_ifm_stride(cfg_ifm_stride),
    .cfg_wgt_base(cfg_wgt_base), .cfg_bias_base(cfg_bias_base),
    .ifm_read(ifm_read), .wgt_read(wgt_read), .bias_read(bias_read),
    .ifm_en(ifm_en), .ifm_addr(ifm_addr), .ifm_rdata(ifm_rdata),
    .wgt_en(wgt_en), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
    .bias_en(bias_en), .bias_addr(bias_addr), .bias_rdata(bias_rdata),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_ifm(pe_ifm),
    .pe_wgt(pe_wgt), .pe_wgt_load(pe_wgt_load), .pe_bias(pe_bias),
    .pe_bias_load(pe_bias_load), .pe_tap(pe_tap), .pe_last(pe_last),
    .err_drop(err_drop)
`ifdef FETCH_PERF_EN
    , .perf_drop_cnt(perf_drop_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] ifm_fn(input logic [IFM_AW-1:0] a);
    return 16'h1000 + 16'(a) * 16'd7;
  endfunction

  function automatic logic [KSIZE*DATA_W-1:0] wgt_fn(input logic [WGT_AW-1:0] a);
    logic [KSIZE*DATA_W-1:0] w;
    for (int k = 0; k < KSIZE; k++) w[k*DATA_W +: DATA_W] = 16'h8000 | (16'(a) << 4) | 16'(k);
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] bias_fn(input logic [BIAS_AW-1:0] a);
    return 16'h4000 ^ (16'(a) * 16'd3);
  endfunction

  // 1-cycle-latency SRAM models
  always @(posedge clk) begin
    if (ifm_en)  ifm_rdata  <= ifm_fn(ifm_addr);
    if (wgt_en)  wgt_rdata  <= wgt_fn(wgt_addr);
    if (bias_en) bias_rdata <= bias_fn(bias_addr);
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop at the negedge before the accepting edge.
  always @(negedge clk) begin
    if (!rst && pe_valid && pe_ready) begin
      fetch_entry_t exp_e, obs;
      check("sb_nonempty", 192'(sb.size() != 0), 192'(1));
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        obs           = '0;
        obs.ifm       = pe_ifm;
        obs.wgt_load  = pe_wgt_load;
        obs.wgt       = pe_wgt_load ? pe_wgt : '0;
        obs.bias_load = pe_bias_load;
        obs.bias      = pe_bias_load ? pe_bias : '0;
        obs.tap       = pe_tap;
        obs.last      = pe_last;
        check("entry", 192'(obs), 192'(exp_e));
      end
    end
  end

  task automatic drive(input logic i, input logic w, input logic b, input logic r,
                       input logic exp_issue);
    logic tap0;
    logic [IFM_AW-1:0] a;
    fetch_entry_t e;
    ifm_read = i; wgt_read = w; bias_read = b; pe_ready = r;
    #2;
    tap0 = exp_issue && (m_tap == 0);
    a = m_win + IFM_AW'(m_tap);
    check("ifm_en", 192'(ifm_en), 192'(exp_issue));
    if (exp_issue) check("ifm_addr", 192'(ifm_addr), 192'(a));
    check("wgt_en", 192'(wgt_en), 192'(tap0));
    if (tap0) check("wgt_addr", 192'(wgt_addr), 192'(m_wgt));
    check("bias_en", 192'(bias_en), 192'(tap0 && b));
    if (tap0 && b) check("bias_addr", 192'(bias_addr), 192'(m_bias));
    if (exp_issue) begin
      e = '0;
      e.ifm  = ifm_fn(a);
      e.tap  = TAP_W'(m_tap);
      e.last = (m_tap == KSIZE - 1);
      if (tap0) begin
        e.wgt_load = 1'b1;
        e.wgt = wgt_fn(m_wgt);
        m_wgt = m_wgt + 1'b1;
        if (b) begin
          e.bias_load = 1'b1;
          e.bias = bias_fn(m_bias);
          m_bias = m_bias + 1'b1;
        end
      end
      sb.push_back(e);
      if (m_tap == KSIZE - 1) begin
        m_tap = 0;
        m_win = m_win + m_stride;
      end else begin
        m_tap++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [IFM_AW-1:0] base, input logic [IFM_AW-1:0] str,
                     input logic [WGT_AW-1:0] w, input logic [BIAS_AW-1:0] b);
    cfg_ifm_base = base; cfg_ifm_stride = str; cfg_wgt_base = w; cfg_bias_base = b;
    cfg_start = 1'b1; ifm_read = 1'b0; wgt_read = 1'b0; bias_read = 1'b0; pe_ready = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    sb.delete();
    m_win = base; m_stride = str; m_wgt = w; m_bias = b; m_tap = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", 192'(sb.size()), 192'(0));
    check("drain_valid", 192'(pe_valid), 192'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    check("rst_pe_valid", 192'(pe_valid), 192'(0));
    check("rst_ifm_en", 192'(ifm_en), 192'(0));
    check("rst_err_drop", 192'(err_drop), 192'(0));
    check("rst_pe_tap", 192'(pe_tap), 192'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    // IDLE ignores strobes
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // 1: first window, tenth strobe is the trailing hold cycle
    cfg(10'h010, 10'd3, 8'h05, 6'h02);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int t = 1; t < KSIZE; t++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // 2: second window; bias_read on taps 1..8 must be ignored
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int t = 1; t < KSIZE; t++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    check("err_drop_clear", 192'(err_drop), 192'(0));

    // 3: back-pressure, overflow drop, retry
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int t = 1; t < 4; t++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("err_drop_set", 192'(err_drop), 192'(1));
    check("stall_tap", 192'(pe_tap), 192'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_tap_hold", 192'(pe_tap), 192'(0));
    check("stall_valid", 192'(pe_valid), 192'(1));
    drain();
    for (int t = 4; t < KSIZE; t++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // 4: full FIFO, continuous push+pop, address wrap
    cfg(10'h3FC, 10'd2, 8'hFF, 6'h3F);
    check("cfg_err_clear", 192'(err_drop), 192'(0));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int t = 1; t < 4; t++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) drive(1'b1, m_tap == 0, m_tap == 0, 1'b1, 1'b1);
    check("no_drop_full", 192'(err_drop), 192'(0));
    drain();

    // 5: asynchronous reset mid-window
    cfg(10'h100, 10'h010, 8'h20, 6'h10);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int t = 1; t < 4; t++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    ifm_read = 1'b1;
    #1;
    check("tap4_en_pre_rst", 192'(ifm_en), 192'(1));
    rst = 1'b1;
    #1;
    check("rst_now_ifm_en", 192'(ifm_en), 192'(0));
    check("rst_now_valid", 192'(pe_valid), 192'(0));
    sb.delete();
    ifm_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cfg(10'h200, 10'd1, 8'h30, 6'h01);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int t = 1; t < KSIZE; t++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

`ifdef FETCH_PERF_EN
    // 6: performance counters
    cfg(10'h000, 10'd1, 8'h00, 6'h00);
    check("perf_drop_zero", 192'(perf_drop_cnt), 192'(0));
    check("perf_stall_zero", 192'(perf_stall_cnt), 192'(0));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int t = 1; t < 4; t++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("perf_drop_3", 192'(perf_drop_cnt), 192'(3));
    check("perf_stall_7", 192'(perf_stall_cnt), 192'(7));
    drain();
    cfg(10'h000, 10'd1, 8'h00, 6'h00);
    check("perf_drop_clr", 192'(perf_drop_cnt), 192'(0));
    check("perf_stall_clr", 192'(perf_stall_cnt), 192'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
